// File: rtl/rf_dump_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_dump_pkg : shared types/constants for the register file and its dump unit
// Rev 1.0
// ---------------------------------------------------------------------------
package rf_dump_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

endpackage : rf_dump_pkg
`default_nettype wire

// File: rtl/regfile_dump_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_dump_unit : walks the register file and streams each word out over
// valid/ready while accumulating an XOR checksum.               Rev 1.0
// ---------------------------------------------------------------------------
module regfile_dump_unit
  import rf_dump_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_rf,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_adr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] rf_adr_q, rf_adr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              hs;

  assign hs = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge reset_rf) begin
    if (reset_rf) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rf_adr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rf_adr_q    <= rf_adr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      checksum_q  <= checksum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (hs) state_d = out_last_q ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; rf_adr always mirrors the next index so that the
  // read port already points at the word when LOAD is entered.
  always_comb begin
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    checksum_d  = checksum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d      = '0;
          checksum_d = '0;
        end
      end
      LOAD: begin
        out_data_d  = rf_rdata;
        out_index_d = idx_q;
        out_last_d  = (idx_q == LAST_IDX);
        out_valid_d = 1'b1;
      end
      SEND: begin
        if (hs) begin
          checksum_d  = checksum_q ^ out_data_q;
          out_valid_d = 1'b0;
          if (!out_last_q) idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
    rf_adr_d = idx_d;
  end

  always_comb begin
    busy = (state_q == LOAD) || (state_q == SEND);
    done = (state_q == DONE);
  end

  assign rf_adr    = rf_adr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign checksum  = checksum_q;

endmodule : regfile_dump_unit
`default_nettype wire

// File: tb/tb_regfile_dump_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_dump_unit : dump unit against a behavioural register file and a
// word-list reference model.                                    Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_dump_unit;
  import rf_dump_pkg::*;

  logic        clk = 1'b0;
  logic        reset_rf;
  logic        start;
  logic        out_ready;
  logic        busy, done, out_valid, out_last;
  logic [4:0]  rf_adr, out_index;
  logic [31:0] rf_rdata, out_data, checksum;

  logic [31:0] rf_mem  [RF_NUM_REGS];
  logic [31:0] exp_mem [RF_NUM_REGS];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          fill;          // 0: i*0x11111111, 1: zero, 2: random
    int          ready_mode;    // 0: always, 1: 1,0,0,1 pattern, 2: random
    int          restart_word;  // index at which a stray start is pulsed, -1 none
    int          wb_word;       // index in SEND at which rf[20] is overwritten, -1 none
    bit          fresh;
    bit          cs_const;
    logic [31:0] exp_cs;
    int          exp_words;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  assign rf_rdata = rf_mem[rf_adr];

  regfile_dump_unit #(
    .NUM_REGS (RF_NUM_REGS),
    .ADDR_W   (RF_ADDR_W),
    .DATA_W   (RF_DATA_W)
  ) dut (
    .clk       (clk),
    .reset_rf  (reset_rf),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rf_adr    (rf_adr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .checksum  (checksum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic do_reset(input bit clear_rf);
    reset_rf  = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    if (clear_rf) begin
      for (int i = 0; i < RF_NUM_REGS; i++) begin
        rf_mem[i]  = '0;
        exp_mem[i] = '0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    reset_rf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    logic [31:0] v;
    for (int i = 0; i < RF_NUM_REGS; i++) begin
      case (mode)
        0:       v = 32'(i) * 32'h1111_1111;
        1:       v = 32'h0;
        default: v = $urandom;
      endcase
      rf_mem[i]  = v;
      exp_mem[i] = v;
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic [31:0] model_cs();
    logic [31:0] c = '0;
    for (int i = 0; i < RF_NUM_REGS; i++) c ^= exp_mem[i];
    return c;
  endfunction

  // Called at a sample point with the DUT idle. Returns the number of words accepted.
  task automatic do_dump(input vec_t v, output int nwords);
    int          cyc = 0;
    bit          last_hs = 0, finished = 0, stalled = 0, wb_done = 0, rs_done = 0;
    logic [31:0] pd;
    logic [4:0]  pi;
    logic        pl;
    nwords = 0;
    pd = '0; pi = '0; pl = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("clear_checksum", checksum, 32'h0);
    while (!finished && cyc < 2000) begin
      start = 1'b0;
      if (last_hs) begin
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_valid", out_valid, 1'b0);
        finished = 1;
        if (v.restart_word >= 0) start = 1'b1;
      end else begin
        check("busy", busy, 1'b1);
        check("no_early_done", done, 1'b0);
        if (!out_valid) check("rf_adr", rf_adr, 32'(nwords));
        if (out_valid && stalled) begin
          check("stall_data", out_data, pd);
          check("stall_index", out_index, pi);
          check("stall_last", out_last, pl);
        end
        if (out_valid && out_index == 5'(v.wb_word) && v.wb_word >= 0 && !wb_done) begin
          rf_mem[20]  = 32'hDEAD_BEEF;
          exp_mem[20] = 32'hDEAD_BEEF;
          wb_done = 1;
        end
        if (out_valid && out_index == 5'(v.restart_word) && v.restart_word >= 0 && !rs_done) begin
          start   = 1'b1;
          rs_done = 1;
        end
        out_ready = pick_ready(v.ready_mode, cyc);
        stalled = out_valid && !out_ready;
        pd = out_data; pi = out_index; pl = out_last;
        if (out_valid && out_ready) begin
          check("index", out_index, 32'(nwords));
          check("data", out_data, exp_mem[nwords % RF_NUM_REGS]);
          check("last", out_last, nwords == RF_NUM_REGS - 1);
          last_hs = (nwords == RF_NUM_REGS - 1);
          nwords++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!finished) check("dump_timeout", 32'h0, 32'h1);
    if (v.restart_word >= 0) begin
      check("start_in_done_ignored", busy, 1'b0);
      check("done_single", done, 1'b0);
    end
  endtask

  initial begin
    int          nw;
    logic [31:0] mcs;
    bit          reached;

    //            fill rdy  rst  wb  fresh const exp_cs         words
    tbl[0] = '{0, 0, -1, -1, 1'b1, 1'b1, 32'h1111_1100, 32};
    tbl[1] = '{0, 1, -1, -1, 1'b0, 1'b1, 32'h1111_1100, 32};
    tbl[2] = '{1, 0, -1, -1, 1'b1, 1'b1, 32'h0000_0000, 32};
    tbl[3] = '{0, 2, 10, -1, 1'b0, 1'b1, 32'h1111_1100, 32};
    tbl[4] = '{2, 2, -1, -1, 1'b0, 1'b0, 32'h0000_0000, 32};
    tbl[5] = '{0, 0, -1,  5, 1'b0, 1'b0, 32'h0000_0000, 32};

    do_reset(1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_adr", rf_adr, 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_index", out_index, 32'h0);
    check("rst_last", out_last, 1'b0);
    check("rst_checksum", checksum, 32'h0);

    for (int r = 0; r < 6; r++) begin
      if (tbl[r].fresh) do_reset(1'b1);
      fill(tbl[r].fill);
      do_dump(tbl[r], nw);
      mcs = model_cs();
      check("word_count", 32'(nw), 32'(tbl[r].exp_words));
      check("checksum_model", checksum, mcs);
      if (tbl[r].cs_const) check("checksum_table", checksum, tbl[r].exp_cs);
      repeat (3) @(posedge clk);
      #1;
      check("checksum_hold", checksum, mcs);
      check("idle_busy", busy, 1'b0);
    end

    // Abort mid-dump: reset while word 7 is waiting in SEND.
    fill(0);
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reached = 0;
    for (int c = 0; c < 200 && !reached; c++) begin
      if (out_valid && out_index == 5'd7) begin
        reached = 1;
      end else begin
        out_ready = out_valid;
        @(posedge clk); #1;
      end
    end
    check("abort_reach_7", 32'(reached), 32'h1);
    out_ready = 1'b0;
    reset_rf  = 1'b1;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_checksum", checksum, 32'h0);
    check("abort_index", out_index, 32'h0);
    check("abort_adr", rf_adr, 32'h0);
    @(posedge clk); #1;
    reset_rf = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("abort_no_done", done, 1'b0);
      check("abort_idle", busy, 1'b0);
      @(posedge clk); #1;
    end
    do_dump(tbl[0], nw);
    check("post_abort_words", 32'(nw), 32'd32);
    check("post_abort_checksum", checksum, 32'h1111_1100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile_dump_unit
`default_nettype wire
